uart_rx_deser: RTL and testbench

- Receive-side UART deserializer: consumes the serial `rxd` line and delivers parallel characters with error status on a valid/ready handshake.
- Generates its own 16x oversampling tick (`sample_clk`) and bit-rate tick (`baud_clk`) from a programmable divisor.
- Sits directly downstream of the serial line; feeds the register/FIFO layer of the UART.

---
 rtl/uart_rx_deser.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - 16x oversampled UART receive deserializer with valid/ready output.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_deser #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rxd,
    input  logic [DIV_W-1:0] cfg_divisor,
    input  logic [1:0]       cfg_char_len,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_even,
    output logic [7:0]       rx_data,
    output logic             rx_parity_err,
    output logic             rx_framing_err,
    output logic             rx_break,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             rx_busy,
    output logic             sample_clk,
    output logic             baud_clk
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_rxd_s1, r_rxd_sync, r_rxd_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [TW-1:0]    r_baud_cnt, r_tick_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [1:0]       r_len;
    logic             r_par_en, r_par_even;
    logic             r_par_err, r_frm_err, r_done;
    logic             r_sample_clk, r_baud_clk;
    logic [7:0]       r_data;
    logic             r_valid, r_out_perr, r_out_ferr, r_overrun;

    logic [DIV_W-1:0] w_div_max;
    logic             w_tick, w_fall, w_mid_pt, w_bit_pt, w_stop_break, w_brk_out;
    logic [2:0]       w_last_bit;

    assign w_div_max  = (cfg_divisor == '0) ? DIV_W'(1) : cfg_divisor;
    // >= rather than == so a divisor lowered mid-count still wraps promptly
    assign w_tick     = (r_div_cnt >= w_div_max - DIV_W'(1));
    assign w_fall     = r_rxd_prev & ~r_rxd_sync;
    assign w_mid_pt   = w_tick && (r_tick_cnt == MID);
    assign w_bit_pt   = w_tick && (r_tick_cnt == LAST);
    assign w_last_bit = 3'd4 + {1'b0, r_len};

`ifdef UART_RX_BREAK_DET_EN
    logic r_zero, r_brk_pend, r_out_brk;
    assign w_stop_break = r_zero & ~r_rxd_sync;
    assign w_brk_out    = r_out_brk;
`else
    assign w_stop_break = 1'b0;
    assign w_brk_out    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rxd_s1     <= 1'b1;
            r_rxd_sync   <= 1'b1;
            r_rxd_prev   <= 1'b1;
            r_div_cnt    <= '0;
            r_baud_cnt   <= '0;
            r_sample_clk <= 1'b0;
            r_baud_clk   <= 1'b0;
        end else begin
            r_rxd_s1     <= rxd;
            r_rxd_sync   <= r_rxd_s1;
            r_rxd_prev   <= r_rxd_sync;
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            r_sample_clk <= w_tick;
            r_baud_clk   <= w_tick && (r_baud_cnt == LAST);
            if (w_tick)
                r_baud_cnt <= (r_baud_cnt == LAST) ? '0 : r_baud_cnt + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_fall) w_state_nxt = S_START;
            S_START:     if (w_mid_pt) w_state_nxt = r_rxd_sync ? S_IDLE : S_DATA;
            S_DATA:      if (w_bit_pt && (r_bit_cnt == w_last_bit))
                             w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            S_PARITY:    if (w_bit_pt) w_state_nxt = S_STOP;
            S_STOP:      if (w_bit_pt) w_state_nxt = w_stop_break ? S_WAIT_IDLE : S_IDLE;
            S_WAIT_IDLE: if (r_rxd_sync) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_len      <= '0;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_zero     <= 1'b0;
            r_brk_pend <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_fall) begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_shift    <= '0;
                    r_par_err  <= 1'b0;
                    r_frm_err  <= 1'b0;
                    r_len      <= cfg_char_len;
                    r_par_en   <= cfg_parity_en;
                    r_par_even <= cfg_parity_even;
`ifdef UART_RX_BREAK_DET_EN
                    r_zero     <= 1'b1;
                    r_brk_pend <= 1'b0;
`endif
                end
            end else if (w_tick) begin
                // Counter restarts at the start-bit midpoint so every later sample lands mid-bit
                if (((r_state == S_START) && w_mid_pt) || (r_tick_cnt == LAST))
                    r_tick_cnt <= '0;
                else
                    r_tick_cnt <= r_tick_cnt + TW'(1);
                if (r_tick_cnt == LAST) begin
                    case (r_state)
                        S_DATA: begin
                            r_shift[r_bit_cnt] <= r_rxd_sync;
                            r_bit_cnt          <= r_bit_cnt + 3'd1;
`ifdef UART_RX_BREAK_DET_EN
                            if (r_rxd_sync) r_zero <= 1'b0;
`endif
                        end
                        S_PARITY: begin
                            r_par_err <= r_rxd_sync ^ (^r_shift) ^ ~r_par_even;
`ifdef UART_RX_BREAK_DET_EN
                            if (r_rxd_sync) r_zero <= 1'b0;
`endif
                        end
                        S_STOP: begin
                            r_frm_err <= ~r_rxd_sync;
                            r_done    <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                            r_brk_pend <= w_stop_break;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_out_perr <= 1'b0;
            r_out_ferr <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_out_brk  <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (r_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data     <= r_shift;
                    r_out_perr <= r_par_err;
                    r_out_ferr <= r_frm_err;
                    r_valid    <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    r_out_brk  <= r_brk_pend;
`endif
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data        = r_data;
    assign rx_parity_err  = r_out_perr;
    assign rx_framing_err = r_out_ferr;
    assign rx_break       = w_brk_out;
    assign rx_valid       = r_valid;
    assign rx_overrun     = r_overrun;
    assign sample_clk     = r_sample_clk;
    assign baud_clk       = r_baud_clk;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - scoreboard bench for uart_rx_deser.
module tb_uart_rx_deser;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] cfg_divisor = 16'd1;
    logic [1:0]  cfg_char_len = 2'd3;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_even = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_parity_err, rx_framing_err, rx_break, rx_valid;
    logic        rx_ready = 1'b1;
    logic        rx_overrun, rx_busy, sample_clk, baud_clk;

    uart_rx_deser dut (
        .clock(clock), .reset(reset), .rxd(rxd),
        .cfg_divisor(cfg_divisor), .cfg_char_len(cfg_char_len),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_even(cfg_parity_even),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_framing_err(rx_framing_err), .rx_break(rx_break),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .rx_busy(rx_busy), .sample_clk(sample_clk), .baud_clk(baud_clk)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ovr_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: one pop per accepted character
    always @(negedge clock) begin
        if (reset && rx_valid && rx_ready) begin
            exp_t g, e;
            g = {rx_data, rx_parity_err, rx_framing_err, rx_break};
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_char got=%0h want=none", g);
            end else begin
                e = q.pop_front();
                check("char{data,pe,fe,brk}", 32'(g), 32'(e));
            end
        end
        if (reset && rx_overrun) ovr_cnt++;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit par_val, input bit stop_val, input int div);
        int bt;
        bt = 16 * div;
        rxd = 1'b0;
        hold(bt);
        for (int i = 0; i < nbits; i++) begin
            rxd = d[i];
            hold(bt);
        end
        if (par_en) begin
            rxd = par_val;
            hold(bt);
        end
        rxd = stop_val;
        hold(bt);
        rxd = 1'b1;
    endtask

    task automatic wait_pulse(input bit use_baud, output int at);
        at = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock);
            #1;
            if (use_baud ? baud_clk : sample_clk) begin
                at = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0, t1, base;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {rx_data, rx_parity_err, rx_framing_err, rx_break, rx_valid,
                                rx_overrun, rx_busy, sample_clk, baud_clk}, 32'h0);
        reset = 1'b1;
        hold(5);

        // 8N1 divisor 1: latency and one-cycle valid with ready high
        q.push_back({8'hA5, 3'b000});
        fork
            send_frame(8'hA5, 8, 0, 0, 1, 1);
            begin
                @(posedge clock);
                lat = 0;
                while (lat < 400) begin
                    @(posedge clock);
                    lat++;
                    #1;
                    if (rx_valid) break;
                end
                check("latency", lat, 155);
                @(posedge clock);
                #1;
                check("valid_width", rx_valid, 0);
            end
        join
        hold(20);

        // 7E1 divisor 4, wrong parity on 0x35 (correct even bit would be 0)
        cfg_divisor = 16'd4; cfg_char_len = 2'd2; cfg_parity_en = 1'b1; cfg_parity_even = 1'b1;
        hold(10);
        wait_pulse(0, t0);
        wait_pulse(0, t1);
        check("sample_period", t1, 4);
        wait_pulse(1, t0);
        wait_pulse(1, t1);
        check("baud_period", t1, 64);
        q.push_back({8'h35, 3'b100});
        send_frame(8'h35, 7, 1, 1, 1, 4);
        hold(60);

        // 8N1 overrun with ready low
        cfg_divisor = 16'd1; cfg_char_len = 2'd3; cfg_parity_en = 1'b0;
        rx_ready = 1'b0;
        hold(20);
        base = ovr_cnt;
        q.push_back({8'h11, 3'b000});
        send_frame(8'h11, 8, 0, 0, 1, 1);
        send_frame(8'h22, 8, 0, 0, 1, 1);
        hold(20);
        check("overrun_pulses", ovr_cnt - base, 1);
        check("held_data", rx_data, 8'h11);
        check("held_valid", rx_valid, 1);
        rx_ready = 1'b1;
        hold(2);
        check("valid_drop", rx_valid, 0);

        // Single-clock glitch is rejected, then a clean frame
        hold(20);
        rxd = 1'b0;
        hold(1);
        rxd = 1'b1;
        hold(2);
        check("glitch_busy_rise", rx_busy, 1);
        hold(10);
        check("glitch_busy_fall", rx_busy, 0);
        check("glitch_no_valid", rx_valid, 0);
        hold(40);
        q.push_back({8'h5A, 3'b000});
        send_frame(8'h5A, 8, 0, 0, 1, 1);
        hold(40);

        // 5N1 framing error, then reset mid-frame
        cfg_char_len = 2'd0;
        q.push_back({8'h1F, 3'b010});
        send_frame(8'h1F, 5, 0, 0, 0, 1);
        hold(40);
        rxd = 1'b0;
        hold(40);
        reset = 1'b0;
        #1;
        check("midframe_reset_outputs", {rx_data, rx_parity_err, rx_framing_err, rx_break,
                                         rx_valid, rx_overrun, rx_busy, sample_clk, baud_clk}, 32'h0);
        hold(5);
        rxd = 1'b1;
        hold(2);
        reset = 1'b1;
        hold(300);
        check("post_reset_valid", rx_valid, 0);
        check("post_reset_busy", rx_busy, 0);

        // Line held low for two frame times
        cfg_char_len = 2'd3;
`ifdef UART_RX_BREAK_DET_EN
        q.push_back({8'h00, 3'b011});
`else
        q.push_back({8'h00, 3'b010});
`endif
        rxd = 1'b0;
        hold(320);
        rxd = 1'b1;
        hold(32);
        q.push_back({8'hC3, 3'b000});
        send_frame(8'hC3, 8, 0, 0, 1, 1);
        hold(40);

        check("queue_empty", q.size(), 0);
        check("total_overruns", ovr_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
